// File: rtl/dmem_mmio.sv
// dmem_mmio: processor data memory with a small memory-mapped I/O block.
//   0x0000-0xBFFF : data RAM, aliased on the low DMEM_AW address bits
//   0xC000 LED, 0xC001 SW, 0xC004 TXDATA, 0xC005 STATUS, 0xC006 RXDATA
//   0xC008 TIMER  : present only when the DMEM_TIMER_EN macro is defined
// Reads are combinational; every side effect lands on the rising clock edge.
//
// TX stream handshake: tx_valid is high exactly while the FIFO is non-empty
// and tx_data then holds the FIFO head. A byte is transferred on every rising
// edge where tx_valid && tx_ready are both high. tx_data is stable while
// tx_valid is held and no transfer has yet occurred.
module dmem_mmio #(
    parameter int DMEM_AW   = 12,
    parameter int TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] daddr,
    input  logic        en,
    input  logic        wr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [7:0]  led,
    input  logic [7:0]  sw,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] A_LED    = 16'hC000;
    localparam logic [15:0] A_SW     = 16'hC001;
    localparam logic [15:0] A_TXDATA = 16'hC004;
    localparam logic [15:0] A_STATUS = 16'hC005;
    localparam logic [15:0] A_RXDATA = 16'hC006;
`ifdef DMEM_TIMER_EN
    localparam logic [15:0] A_TIMER  = 16'hC008;
`endif

    logic [15:0] mem [0:(1 << DMEM_AW) - 1];
    logic [7:0]  fifo [0:TXQ_DEPTH - 1];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic        tx_ovf, rx_ovr, rx_avail;
    logic [7:0]  rx_hold;

    logic is_ram, wr_cyc, rd_cyc;
    logic tx_push_req, tx_push, tx_pop, tx_drop;
    logic tx_empty, tx_full, stat_wr, rx_rd;

    assign is_ram      = (daddr < 16'hC000);
    assign wr_cyc      = en & wr;
    assign rd_cyc      = en & ~wr;
    assign tx_push_req = wr_cyc & (daddr == A_TXDATA);
    assign stat_wr     = wr_cyc & (daddr == A_STATUS);
    assign rx_rd       = rd_cyc & (daddr == A_RXDATA);

    assign tx_empty = (count == '0);
    assign tx_full  = (count == CW'(TXQ_DEPTH));
    assign tx_valid = ~tx_empty;
    assign tx_data  = fifo[rptr];
    assign tx_pop   = tx_valid & tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign tx_push  = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop  = tx_push_req & tx_full & ~tx_pop;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_cyc && is_ram) mem[daddr[DMEM_AW-1:0]] <= data_in;
    end

    // FIFO storage; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (tx_push) fifo[wptr] <= data_in[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_push) wptr <= wptr + 1'b1;
            if (tx_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(tx_push) - CW'(tx_pop);
            if (stat_wr) tx_ovf <= 1'b0;
            if (tx_drop) tx_ovf <= 1'b1;
        end
    end

    // RX holding register; a read coinciding with a new byte is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold  <= 8'h00;
            rx_avail <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_hold  <= rx_data;
                rx_avail <= 1'b1;
            end else if (rx_rd) begin
                rx_avail <= 1'b0;
            end
            if (stat_wr) rx_ovr <= 1'b0;
            if (rx_valid && rx_avail && !rx_rd) rx_ovr <= 1'b1;
        end
    end

    // LED register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               led <= 8'h00;
        else if (wr_cyc && (daddr == A_LED))      led <= data_in[7:0];
    end

`ifdef DMEM_TIMER_EN
    logic [15:0] timer;

    // Free-running cycle counter, wraps naturally; a write zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               timer <= 16'h0000;
        else if (wr_cyc && (daddr == A_TIMER))    timer <= 16'h0000;
        else                                      timer <= timer + 16'd1;
    end
`endif

    // Combinational read mux; idle cycles return zero.
    always_comb begin
        data_out = 16'h0000;
        if (rd_cyc) begin
            if (is_ram) begin
                data_out = mem[daddr[DMEM_AW-1:0]];
            end else begin
                case (daddr)
                    A_LED:    data_out = {8'h00, led};
                    A_SW:     data_out = {8'h00, sw};
                    A_STATUS: data_out = {11'h000, tx_ovf, rx_ovr, rx_avail,
                                          tx_empty, tx_full};
                    A_RXDATA: data_out = {8'h00, rx_hold};
`ifdef DMEM_TIMER_EN
                    A_TIMER:  data_out = timer;
`endif
                    default:  data_out = 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed accesses with hand-computed expectations.
// Read results and TX bytes are queued as they are requested and checked by
// separate monitors sampling on the falling clock edge.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] daddr = '0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic [7:0]  led;
    logic [7:0]  sw = 8'h5A;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];

    dmem_mmio #(.DMEM_AW(12), .TXQ_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .daddr    (daddr),
        .en       (en),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .led      (led),
        .sw       (sw),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // read-data monitor
    always @(negedge clk) begin
        if (rst_n && en && !wr) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", data_out, 16'hxxxx);
            end else begin
                check($sformatf("rd_0x%04h", daddr), data_out, exp_q.pop_front());
            end
        end
    end

    // TX stream monitor
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected", {8'h00, tx_data}, 16'hxxxx);
            end else begin
                check("tx_byte", {8'h00, tx_data}, {8'h00, tx_q.pop_front()});
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        daddr = a; en = 1'b1; wr = 1'b0;
        exp_q.push_back(e);
        tick(1);
        en = 1'b0;
    endtask

    task automatic wrt(input logic [15:0] a, input logic [15:0] d);
        daddr = a; data_in = d; en = 1'b1; wr = 1'b1;
        tick(1);
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic rx(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_led", {8'h00, led}, 16'h0000);
        check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("idle_data_out", data_out, 16'h0000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rd(16'hC005, 16'h0002);
`ifdef DMEM_TIMER_EN
        wrt(16'hC008, 16'h0000);
        rd(16'hC008, 16'h0000);
        rd(16'hC008, 16'h0001);
`else
        rd(16'hC008, 16'h0000);
`endif

        // RAM write, read and aliasing
        wrt(16'h0010, 16'h1234);
        rd(16'h0010, 16'h1234);
        rd(16'h1010, 16'h1234);
        wrt(16'hBFF0, 16'hBEEF);
        rd(16'h0FF0, 16'hBEEF);

        // LED, SW and unmapped space
        wrt(16'hC000, 16'h00A5);
        check("led_after_write", {8'h00, led}, 16'h00A5);
        rd(16'hC000, 16'h00A5);
        rd(16'hC003, 16'h0000);
        wrt(16'hC001, 16'hFFFF);
        rd(16'hC001, 16'h005A);
        wrt(16'hC00F, 16'h0011);
        check("led_unmapped_write", {8'h00, led}, 16'h00A5);
        rd(16'hC004, 16'h0000);

        // overflow: five pushes into a depth-4 FIFO with no sink
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wrt(16'hC004, 16'(i));
            if (i <= 4) tx_q.push_back(8'(i));
        end
        rd(16'hC005, 16'h0011);
        tx_ready = 1'b1;
        tick(6);
        check("tx_drained_valid", {15'h0, tx_valid}, 16'h0000);
        check("tx_q_left", 16'(tx_q.size()), 16'h0000);
        wrt(16'hC005, 16'h0000);
        rd(16'hC005, 16'h0002);

        // push into a full FIFO in the same cycle as a pop
        tx_ready = 1'b0;
        wrt(16'hC004, 16'h00AA); tx_q.push_back(8'hAA);
        wrt(16'hC004, 16'h00BB); tx_q.push_back(8'hBB);
        wrt(16'hC004, 16'h00CC); tx_q.push_back(8'hCC);
        wrt(16'hC004, 16'h00DD); tx_q.push_back(8'hDD);
        tx_ready = 1'b1;
        wrt(16'hC004, 16'h0077); tx_q.push_back(8'h77);
        tick(6);
        check("tx_q_left_2", 16'(tx_q.size()), 16'h0000);
        rd(16'hC005, 16'h0002);

        // RX overrun: two bytes, no read in between
        rx(8'h3C);
        rx(8'h4D);
        rd(16'hC005, 16'h000E);
        rd(16'hC006, 16'h004D);
        rd(16'hC005, 16'h000A);
        wrt(16'hC005, 16'h0000);
        rd(16'hC005, 16'h0002);

        // RX byte arriving during an RXDATA read
        rx(8'h11);
        rx_data = 8'h22; rx_valid = 1'b1;
        rd(16'hC006, 16'h0011);
        rx_valid = 1'b0;
        rd(16'hC005, 16'h0006);
        rd(16'hC006, 16'h0022);
        rd(16'hC005, 16'h0002);

        // reset with bytes queued
        tx_ready = 1'b0;
        wrt(16'hC004, 16'h0001);
        wrt(16'hC004, 16'h0002);
        wrt(16'hC004, 16'h0003);
        wrt(16'hC000, 16'h003C);
        check("pre_rst_tx_valid", {15'h0, tx_valid}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("mid_rst_led", {8'h00, led}, 16'h0000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rd(16'hC005, 16'h0002);
        rd(16'h0010, 16'h1234);
        tx_ready = 1'b1;
        tick(3);
        check("post_rst_tx_valid", {15'h0, tx_valid}, 16'h0000);

        check("rd_q_left", 16'(exp_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
